// File: rtl/sram_pkg.sv
// Shared types for the 32-bit to 16-bit SRAM word bridge.
// Holds FSM/op encodings and SRAM bus geometry.
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } op_t;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

endpackage

// File: rtl/sram_word_bridge.sv
// Memory-stage bridge: one 32-bit load/store becomes two
// 16-bit SRAM cycles, low half first, stalling the core.
module sram_word_bridge
  import sram_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = SRAM_ADDR_W,
  parameter int DATA_W      = SRAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              ready,
  output logic              stall,
  output logic              SRAMWEn,
  output logic [ADDR_W-1:0] SRAMaddress,
  inout  wire  [DATA_W-1:0] SRAMdata
);

  localparam int PW = $clog2(WAIT_CYCLES + 1);
  localparam logic [PW-1:0] LAST = PW'(WAIT_CYCLES);

  state_t              state_q;
  state_t              state_d;
  logic [PW-1:0]       phase_q;
  logic [PW-1:0]       phase_d;
  op_t                 op_q;
  op_t                 op_d;
  logic [ADDR_W-2:0]   addr_q;
  logic [ADDR_W-2:0]   addr_d;
  logic [31:0]         wdata_q;
  logic [31:0]         wdata_d;
  logic [DATA_W-1:0]   lo_q;
  logic [31:0]         rdata_q;

  logic                we_n_q;
  logic                we_n_d;
  logic                oe_q;
  logic                oe_d;
  logic [DATA_W-1:0]   dout_q;
  logic [DATA_W-1:0]   dout_d;
  logic [ADDR_W-1:0]   sa_q;
  logic [ADDR_W-1:0]   sa_d;

  logic                in_half;
  logic                last_ph;
  logic                half_d;
  logic                wr_half;
  logic                unused_addr;

  assign unused_addr = ^{mem_addr[31:ADDR_W+1], mem_addr[1:0]};

  assign in_half = (state_q == LOW) || (state_q == HIGH);
  assign last_ph = in_half && (phase_q == LAST);

  // Bus registers are loaded from next-state values so
  // they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      op_q    <= RD;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      rdata_q <= '0;
      we_n_q  <= 1'b1;
      oe_q    <= 1'b0;
      dout_q  <= '0;
      sa_q    <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_n_q  <= we_n_d;
      oe_q    <= oe_d;
      dout_q  <= dout_d;
      sa_q    <= sa_d;
      if (op_q == RD && last_ph) begin
        if (state_q == LOW) begin
          lo_q <= SRAMdata;
        end else begin
          rdata_q <= {SRAMdata, lo_q};
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        phase_d = '0;
        if (mem_write) begin
          op_d    = WR;
          addr_d  = mem_addr[ADDR_W:2];
          wdata_d = mem_wdata;
          state_d = LOW;
        end else if (mem_read) begin
          op_d    = RD;
          addr_d  = mem_addr[ADDR_W:2];
          state_d = LOW;
        end
      end
      LOW: begin
        if (phase_q == LAST) begin
          phase_d = '0;
          state_d = HIGH;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      HIGH: begin
        if (phase_q == LAST) begin
          phase_d = '0;
          state_d = DONE;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      DONE: begin
        phase_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Last phase of a write half is a hold cycle with WEn high.
  always_comb begin
    half_d  = (state_d == HIGH) ? HALF_HI : HALF_LO;
    wr_half = (op_d == WR) &&
              ((state_d == LOW) || (state_d == HIGH));
    oe_d    = wr_half;
    we_n_d  = ~(wr_half && (phase_d != LAST));
    sa_d    = {addr_d, half_d};
    dout_d  = half_d ? wdata_d[31:16] : wdata_d[15:0];
  end

  assign SRAMWEn     = we_n_q | rst;
  assign SRAMdata    = (oe_q && !rst) ? dout_q : 'z;
  assign SRAMaddress = sa_q;
  assign mem_rdata   = rdata_q;
  assign ready       = (state_q == DONE);
  assign stall       = (mem_read | mem_write) & ~ready;

endmodule

// File: tb/tb_sram_word_bridge.sv
// Directed bench for sram_word_bridge with a
// behavioural 16-bit SRAM on the bus.
module tb_sram_word_bridge;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        ready;
  logic        stall;
  logic        SRAMWEn;
  logic [17:0] SRAMaddress;
  wire  [15:0] sram_data;

  logic [15:0] mem [0:262143];
  logic        model_en;

  int checks;
  int failures;

  sram_word_bridge dut (
    .clk         (clk),
    .rst         (rst),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .ready       (ready),
    .stall       (stall),
    .SRAMWEn     (SRAMWEn),
    .SRAMaddress (SRAMaddress),
    .SRAMdata    (sram_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign sram_data =
    (model_en && mem_read && !mem_write && SRAMWEn)
      ? mem[SRAMaddress] : 16'hzzzz;

  always @(posedge clk) begin
    if (!SRAMWEn) mem[SRAMaddress] <= sram_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_access(
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output int          rdy_cyc,
    output logic [31:0] rdata,
    output int          wen_lo,
    output int          stall_bad,
    output int          bus_bad
  );
    rdy_cyc   = -1;
    rdata     = '0;
    wen_lo    = 0;
    stall_bad = 0;
    bus_bad   = 0;
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = addr;
    mem_wdata = wdata;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (SRAMWEn === 1'b0) wen_lo++;
      if (rd && !wr) begin
        if (SRAMWEn !== 1'b1) bus_bad++;
        if (c > 0 && c < 5 &&
            sram_data !== mem[SRAMaddress]) bus_bad++;
      end
      if (ready === 1'b1) begin
        rdy_cyc = c;
        rdata   = mem_rdata;
        if (stall !== 1'b0) stall_bad++;
      end else if (stall !== 1'b1) begin
        stall_bad++;
      end
      step();
      if (rdy_cyc >= 0) break;
    end
  endtask

  task automatic go_idle();
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic test_reset();
    logic r;
    logic w;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      r         = 1'($urandom);
      w         = 1'($urandom);
      mem_read  = r;
      mem_write = w;
      mem_addr  = $urandom;
      mem_wdata = $urandom;
      @(negedge clk);
      checks++;
      if (SRAMWEn !== 1'b1) begin
        failures++;
        $display("FAIL reset_wen got=%b exp=1", SRAMWEn);
      end
      checks++;
      if (ready !== 1'b0) begin
        failures++;
        $display("FAIL reset_ready got=%b exp=0", ready);
      end
      checks++;
      if (stall !== (r | w)) begin
        failures++;
        $display("FAIL reset_stall got=%b exp=%b",
                 stall, r | w);
      end
      step();
    end
    go_idle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_rdata !== 32'h0 || SRAMaddress !== 18'h0) begin
      failures++;
      $display("FAIL reset_regs got=%h/%h exp=0/0",
               mem_rdata, SRAMaddress);
    end
    step();
  endtask

  task automatic test_store();
    int rc, wl, sb, bb;
    logic [31:0] rd;
    do_access(1'b0, 1'b1, 32'h100, 32'hDEADBEEF,
              rc, rd, wl, sb, bb);
    go_idle();
    @(negedge clk);
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL store_ready_pulse got=%b exp=0", ready);
    end
    step();
    checks++;
    if (rc != 5) begin
      failures++;
      $display("FAIL store_latency got=%0d exp=5", rc);
    end
    checks++;
    if (wl != 2) begin
      failures++;
      $display("FAIL store_wen_cycles got=%0d exp=2", wl);
    end
    checks++;
    if (sb != 0) begin
      failures++;
      $display("FAIL store_stall bad=%0d exp=0", sb);
    end
    checks++;
    if (mem[18'h080] !== 16'hBEEF) begin
      failures++;
      $display("FAIL store_lo got=%h exp=beef", mem[18'h080]);
    end
    checks++;
    if (mem[18'h081] !== 16'hDEAD) begin
      failures++;
      $display("FAIL store_hi got=%h exp=dead", mem[18'h081]);
    end
  endtask

  task automatic test_load();
    int rc, wl, sb, bb;
    logic [31:0] rd;
    do_access(1'b1, 1'b0, 32'h100, 32'h0,
              rc, rd, wl, sb, bb);
    go_idle();
    step();
    checks++;
    if (rc != 5) begin
      failures++;
      $display("FAIL load_latency got=%0d exp=5", rc);
    end
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL load_data got=%h exp=deadbeef", rd);
    end
    checks++;
    if (bb != 0 || wl != 0 || sb != 0) begin
      failures++;
      $display("FAIL load_bus bus=%0d wen=%0d stall=%0d exp=0",
               bb, wl, sb);
    end
  endtask

  task automatic test_back_to_back();
    int rc, wl, sb, bb;
    logic [31:0] rd;
    do_access(1'b0, 1'b1, 32'h0007FFFC, 32'h12345678,
              rc, rd, wl, sb, bb);
    checks++;
    if (rc != 5 || rd !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL b2b_store got=%0d/%h exp=5/deadbeef",
               rc, rd);
    end
    do_access(1'b1, 1'b0, 32'hFFF7FFFC, 32'h0,
              rc, rd, wl, sb, bb);
    go_idle();
    step();
    checks++;
    if (mem[18'h3FFFE] !== 16'h5678 ||
        mem[18'h3FFFF] !== 16'h1234) begin
      failures++;
      $display("FAIL b2b_mem got=%h/%h exp=5678/1234",
               mem[18'h3FFFE], mem[18'h3FFFF]);
    end
    checks++;
    if (rc != 5 || rd !== 32'h12345678) begin
      failures++;
      $display("FAIL b2b_load got=%0d/%h exp=5/12345678",
               rc, rd);
    end
  endtask

  task automatic test_priority();
    int rc, wl, sb, bb;
    logic [31:0] rd;
    do_access(1'b1, 1'b1, 32'h200, 32'hA5A55A5A,
              rc, rd, wl, sb, bb);
    go_idle();
    step();
    checks++;
    if (mem[18'h100] !== 16'h5A5A ||
        mem[18'h101] !== 16'hA5A5) begin
      failures++;
      $display("FAIL prio_mem got=%h/%h exp=5a5a/a5a5",
               mem[18'h100], mem[18'h101]);
    end
    checks++;
    if (rc != 5 || wl != 2 || rd !== 32'h12345678) begin
      failures++;
      $display("FAIL prio_op got=%0d/%0d/%h exp=5/2/12345678",
               rc, wl, rd);
    end
  endtask

  task automatic test_reset_mid();
    int rc, wl, sb, bb;
    int rdy_seen;
    logic [31:0] rd;
    do_access(1'b0, 1'b1, 32'h300, 32'h77776666,
              rc, rd, wl, sb, bb);
    go_idle();
    step();
    mem_write = 1'b1;
    mem_addr  = 32'h300;
    mem_wdata = 32'hCAFEF00D;
    step();
    step();
    step();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (SRAMWEn !== 1'b1 || ready !== 1'b0) begin
      failures++;
      $display("FAIL abort_now wen=%b ready=%b exp=1/0",
               SRAMWEn, ready);
    end
    step();
    rst = 1'b0;
    go_idle();
    rdy_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ready !== 1'b0 || SRAMWEn !== 1'b1 ||
          stall !== 1'b0) rdy_seen++;
      step();
    end
    checks++;
    if (rdy_seen != 0) begin
      failures++;
      $display("FAIL abort_idle bad=%0d exp=0", rdy_seen);
    end
    checks++;
    if (mem[18'h180] !== 16'hF00D ||
        mem[18'h181] !== 16'h7777) begin
      failures++;
      $display("FAIL abort_mem got=%h/%h exp=f00d/7777",
               mem[18'h180], mem[18'h181]);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    model_en  = 1'b1;
    rst       = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    step();
    test_reset();
    test_store();
    test_load();
    test_back_to_back();
    test_priority();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
